// File: rtl/lever_adc_frontend_pkg.sv
`default_nettype none
// ============================================================================
// lever_adc_pkg : shared types and constants for the lever ADC front end
// Rev 1.0
// ============================================================================
package lever_adc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4,
        PROCESS  = 3'd5
    } state_t;

    localparam logic [11:0] ADC_CENTER = 12'd2048;

    localparam logic [1:0] CMD_START = 2'b11;
    localparam logic       CMD_SGL   = 1'b1;

    localparam logic signed [31:0] SAT_MAX = 32'sd32767;
    localparam logic signed [31:0] SAT_MIN = -32'sd32768;

    function automatic logic [15:0] cmd_word(input logic ch);
        return {CMD_START, ch, CMD_SGL, 12'b0};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end
        return v[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lever_adc_frontend_frame.sv
`default_nettype none
// ============================================================================
// spi_adc_frame : one 16-bit mode-0 SPI frame (CS setup, 16 SCLK, CS hold)
// Rev 1.0
// ============================================================================
module spi_adc_frame
    import lever_adc_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic        ch_i,
    input  logic        miso_i,
    output logic        cs_n_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        done_o,
    output logic [11:0] result_o,
    output state_t      state_o
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       half_q;
    logic [15:0]      cmd_q;
    logic [11:0]      rx_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             mosi_q;
    logic [1:0]       miso_sync_q;
    logic             w_div_end;

    assign w_div_end = (div_q == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso_sync_q <= 2'b00;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= 5'd0;
            cmd_q   <= 16'd0;
            rx_q    <= 12'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= CS_SETUP;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                        cmd_q   <= cmd_word(ch_i);
                    end
                end
                CS_SETUP: begin
                    if (w_div_end) begin
                        state_q <= SHIFT;
                        div_q   <= '0;
                        half_q  <= 5'd0;
                        mosi_q  <= cmd_q[15];
                        cmd_q   <= {cmd_q[14:0], 1'b0};
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_div_end) begin
                        div_q  <= '0;
                        half_q <= half_q + 5'd1;
                        // Even halves are SCLK low; MISO is captured on the rising transition.
                        if (!half_q[0]) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[10:0], miso_sync_q[1]};
                        end else begin
                            sclk_q <= 1'b0;
                            if (half_q == 5'd31) begin
                                state_q <= CS_HOLD;
                            end else begin
                                mosi_q <= cmd_q[15];
                                cmd_q  <= {cmd_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (w_div_end) begin
                        state_q <= IDLE;
                        div_q   <= '0;
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o   = (state_q == CS_HOLD) && w_div_end;
    assign result_o = rx_q;
    assign cs_n_o   = cs_n_q;
    assign sclk_o   = sclk_q;
    assign mosi_o   = mosi_q;
    assign state_o  = state_q;

endmodule
`default_nettype wire

// File: rtl/lever_adc_frontend.sv
`default_nettype none
// ============================================================================
// lever_adc_frontend : periodic dual-channel lever sampling to signed 14.2
// Optional: LEVER_AVG_EN enables a 4-sample moving average per channel.
// Rev 1.0
// ============================================================================
module lever_adc_frontend
    import lever_adc_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 50_000,
    parameter int CLK_DIV       = 25,
    parameter int DEADBAND      = 8,
    parameter int ACC_GAIN      = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_mosi,
    input  logic        adc_miso,
    output logic [15:0] al1Bits,
    output logic [15:0] al2Bits,
    output logic        sample_valid,
    output logic        overrun,
    output logic [2:0]  db_state
);

    localparam int               PER_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [PER_W-1:0] per_q;
    state_t           state_q;
    logic             ch_q;
    logic [DIV_W-1:0] gap_q;
    logic [11:0]      raw0_q;
    logic [11:0]      raw1_q;
    logic [15:0]      al1_q;
    logic [15:0]      al2_q;
    logic             valid_q;
    logic             overrun_q;

    logic             w_trigger;
    logic             w_start;
    logic             w_done;
    logic [11:0]      w_result;
    state_t           w_frame_state;
    logic [11:0]      w_in0;
    logic [11:0]      w_in1;

    function automatic logic [15:0] lever_scale(input logic [11:0] raw);
        logic signed [12:0] c;
        int                 ci;
        c  = $signed({1'b0, raw}) - $signed({1'b0, ADC_CENTER});
        ci = int'(c);
        if (ci <= DEADBAND && ci >= -DEADBAND) begin
            ci = 0;
        end
        return sat16(ci * ACC_GAIN);
    endfunction

    assign w_trigger = (per_q == PER_W'(SAMPLE_PERIOD - 1));
    assign w_start   = ((state_q == IDLE) && w_trigger) ||
                       ((state_q == GAP) && (gap_q == DIV_LAST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_q <= '0;
        end else if (w_trigger) begin
            per_q <= '0;
        end else begin
            per_q <= per_q + 1'b1;
        end
    end

    spi_adc_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clock    (clock),
        .reset    (reset),
        .start_i  (w_start),
        .ch_i     (state_q == GAP),
        .miso_i   (adc_miso),
        .cs_n_o   (adc_cs_n),
        .sclk_o   (adc_sclk),
        .mosi_o   (adc_mosi),
        .done_o   (w_done),
        .result_o (w_result),
        .state_o  (w_frame_state)
    );

`ifdef LEVER_AVG_EN
    logic [2:0][11:0] hist0_q;
    logic [2:0][11:0] hist1_q;
    logic [13:0]      w_sum0;
    logic [13:0]      w_sum1;

    assign w_sum0 = {2'b00, raw0_q} + {2'b00, hist0_q[0]} + {2'b00, hist0_q[1]} + {2'b00, hist0_q[2]};
    assign w_sum1 = {2'b00, raw1_q} + {2'b00, hist1_q[0]} + {2'b00, hist1_q[1]} + {2'b00, hist1_q[2]};
    assign w_in0  = w_sum0[13:2];
    assign w_in1  = w_sum1[13:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist0_q <= {3{ADC_CENTER}};
            hist1_q <= {3{ADC_CENTER}};
        end else if (state_q == PROCESS) begin
            hist0_q <= {hist0_q[1:0], raw0_q};
            hist1_q <= {hist1_q[1:0], raw1_q};
        end
    end
`else
    assign w_in0 = raw0_q;
    assign w_in1 = raw1_q;
`endif

    // CS_SETUP here means "a frame is in flight"; the frame engine reports the detailed phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ch_q      <= 1'b0;
            gap_q     <= '0;
            raw0_q    <= 12'd0;
            raw1_q    <= 12'd0;
            al1_q     <= 16'd0;
            al2_q     <= 16'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (w_trigger && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (w_trigger) begin
                        state_q <= CS_SETUP;
                        ch_q    <= 1'b0;
                    end
                end
                CS_SETUP: begin
                    if (w_done) begin
                        if (!ch_q) begin
                            raw0_q  <= w_result;
                            gap_q   <= '0;
                            state_q <= GAP;
                        end else begin
                            raw1_q  <= w_result;
                            state_q <= PROCESS;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == DIV_LAST) begin
                        state_q <= CS_SETUP;
                        ch_q    <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                PROCESS: begin
                    al1_q   <= lever_scale(w_in0);
                    al2_q   <= lever_scale(w_in1);
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign al1Bits      = al1_q;
    assign al2Bits      = al2_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign db_state     = (state_q == CS_SETUP) ? w_frame_state : state_q;

endmodule
`default_nettype wire
